// File: rtl/tpu_matrix_multiply_unit.sv
// ---------------------------------------------------------------------------
// tpu_matrix_multiply_unit
//
// Weight-stationary MATRIX_WIDTH x MATRIX_WIDTH multiply-accumulate array.
// Weight rows are written into a shadow buffer and copied into the active
// array by a token that moves down one row per enabled cycle. Input vectors
// arrive diagonally skewed (lane k one cycle behind lane k-1). Each array row
// adds its products to the partial sum handed down from the row above. After
// row N-1 there are two more register stages, so the columns of a result row
// come out aligned.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   enable          advances psums, sign pipeline, activation token, outputs
//   weight_data     one weight row, element j -> column j
//   weight_signed   weight_data is two's complement (stored with the row)
//   systolic_data   skewed input, lane k feeds array row k
//   systolic_signed current input row (lane 0) is two's complement
//   activate_weight start copying shadow weights into the active array
//   load_weight     write weight_data into shadow row weight_addr
//   weight_addr     shadow row index (values >= MATRIX_WIDTH are ignored)
//   result          one result row, 32 bits per column
//
// Optional build macro MMU_RESULT_VALID_EN adds systolic_valid (qualifies
// lane 0) and result_valid (high exactly while result holds a valid row).
// ---------------------------------------------------------------------------
module tpu_matrix_multiply_unit #(
    parameter int MATRIX_WIDTH = 14
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [MATRIX_WIDTH-1:0][7:0]       weight_data,
    input  logic                               weight_signed,
    input  logic [MATRIX_WIDTH-1:0][7:0]       systolic_data,
    input  logic                               systolic_signed,
    input  logic                               activate_weight,
    input  logic                               load_weight,
    input  logic [7:0]                         weight_addr,
`ifdef MMU_RESULT_VALID_EN
    input  logic                               systolic_valid,
    output logic                               result_valid,
`endif
    output logic [MATRIX_WIDTH-1:0][31:0]      result
);
    localparam int N = MATRIX_WIDTH;

    logic [N-1:0][N-1:0][7:0]  shadow_w_q, shadow_w_d;
    logic [N-1:0]              shadow_s_q, shadow_s_d;
    logic [N-1:0][N-1:0][7:0]  active_w_q, active_w_d;
    logic [N-1:0]              active_s_q, active_s_d;
    // token_q[k-1] set: row k copies its shadow row at the next enabled edge
    logic [N-2:0]              token_q, token_d;
    // lane_sgn_q[k-1]: signed flag travelling alongside lane k
    logic [N-2:0]              lane_sgn_q, lane_sgn_d;
    logic [N-1:0][N-1:0][31:0] psum_q, psum_d;
    logic [N-1:0][31:0]        stage_q, stage_d;
    logic [N-1:0][31:0]        result_q, result_d;

    logic [N-1:0]              load_row;
    logic [N-1:0]              lane_sgn;
    logic [N-1:0][N-1:0][7:0]  eff_w;
    logic [N-1:0]              eff_s;
    logic [N-1:0][N-1:0][31:0] prod;

    always_comb begin
        load_row    = '0;
        lane_sgn    = '0;
        load_row[0] = enable & activate_weight;
        lane_sgn[0] = systolic_signed;
        for (int k = 1; k < N; k++) begin
            load_row[k] = enable & token_q[k-1];
            lane_sgn[k] = lane_sgn_q[k-1];
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            logic signed [8:0] x9;
            // A row being activated on this edge already computes with the
            // incoming weights, so the shadow row is bypassed straight in.
            assign eff_w[gi] = load_row[gi] ? shadow_w_q[gi] : active_w_q[gi];
            assign eff_s[gi] = load_row[gi] ? shadow_s_q[gi] : active_s_q[gi];
            assign x9        = {lane_sgn[gi] & systolic_data[gi][7], systolic_data[gi]};
            for (gj = 0; gj < N; gj++) begin : g_col
                logic signed [8:0]  w9;
                logic signed [17:0] p;
                assign w9 = {eff_s[gi] & eff_w[gi][gj][7], eff_w[gi][gj]};
                assign p  = x9 * w9;
                assign prod[gi][gj] = {{14{p[17]}}, p};
            end
        end
    endgenerate

    always_comb begin
        shadow_w_d = shadow_w_q;
        shadow_s_d = shadow_s_q;
        active_w_d = active_w_q;
        active_s_d = active_s_q;
        token_d    = token_q;
        lane_sgn_d = lane_sgn_q;
        psum_d     = psum_q;
        stage_d    = stage_q;
        result_d   = result_q;

        // Weight writes ignore enable; an out-of-range address matches no row.
        for (int r = 0; r < N; r++) begin
            if (load_weight && (weight_addr == 8'(r))) begin
                shadow_w_d[r] = weight_data;
                shadow_s_d[r] = weight_signed;
            end
        end

        for (int r = 0; r < N; r++) begin
            if (load_row[r]) begin
                active_w_d[r] = shadow_w_q[r];
                active_s_d[r] = shadow_s_q[r];
            end
        end

        if (enable) begin
            token_d    = load_row[N-2:0];
            lane_sgn_d = lane_sgn[N-2:0];
            for (int j = 0; j < N; j++) begin
                psum_d[0][j] = prod[0][j];
            end
            for (int k = 1; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    psum_d[k][j] = psum_q[k-1][j] + prod[k][j];
                end
            end
            stage_d  = psum_q[N-1];
            result_d = stage_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_w_q <= '0;
            shadow_s_q <= '0;
            active_w_q <= '0;
            active_s_q <= '0;
            token_q    <= '0;
            lane_sgn_q <= '0;
            psum_q     <= '0;
            stage_q    <= '0;
            result_q   <= '0;
        end else begin
            shadow_w_q <= shadow_w_d;
            shadow_s_q <= shadow_s_d;
            active_w_q <= active_w_d;
            active_s_q <= active_s_d;
            token_q    <= token_d;
            lane_sgn_q <= lane_sgn_d;
            psum_q     <= psum_d;
            stage_q    <= stage_d;
            result_q   <= result_d;
        end
    end

    assign result = result_q;

`ifdef MMU_RESULT_VALID_EN
    // valid_q[m] is set m enabled edges after lane 0 was sampled; the result
    // row lands N+1 edges later, so the top bit tracks it exactly.
    logic [N+1:0] valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (enable) begin
            valid_d = {valid_q[N:0], systolic_valid};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign result_valid = valid_q[N+1];
`endif

endmodule

// File: tb/tb_tpu_matrix_multiply_unit.sv
// ---------------------------------------------------------------------------
// tb_tpu_matrix_multiply_unit
//
// Drives weight loads and skewed input streams into a 4x4 array and compares
// every result row with a reference computed directly as
// result[j] = sum_k x[k]*W[k][j] (wrapped to 32 bits). A row uses the newly
// activated weights exactly when its lane-0 edge is at or after the
// activation edge; otherwise it uses the previously active weights.
// ---------------------------------------------------------------------------
module tb_tpu_matrix_multiply_unit;
    localparam int N    = 4;
    localparam int MAXR = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 enable;
    logic [N-1:0][7:0]    weight_data;
    logic                 weight_signed;
    logic [N-1:0][7:0]    systolic_data;
    logic                 systolic_signed;
    logic                 activate_weight;
    logic                 load_weight;
    logic [7:0]           weight_addr;
    logic [N-1:0][31:0]   result;
`ifdef MMU_RESULT_VALID_EN
    logic                 systolic_valid;
    logic                 result_valid;
`endif

    tpu_matrix_multiply_unit #(.MATRIX_WIDTH(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .weight_data     (weight_data),
        .weight_signed   (weight_signed),
        .systolic_data   (systolic_data),
        .systolic_signed (systolic_signed),
        .activate_weight (activate_weight),
        .load_weight     (load_weight),
        .weight_addr     (weight_addr),
`ifdef MMU_RESULT_VALID_EN
        .systolic_valid  (systolic_valid),
        .result_valid    (result_valid),
`endif
        .result          (result)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] shd_w [N][N];
    bit         shd_s [N];
    logic [7:0] act_w [N][N];
    bit         act_s [N];
    logic [7:0] new_w [N][N];
    bit         new_s [N];
    logic [7:0] xr    [MAXR][N];
    bit         xsg   [MAXR];

    task automatic check(input string tag, input logic [N*32-1:0] obs,
                         input logic [N*32-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic int ext8(input logic [7:0] v, input bit s);
        if (s) return int'($signed(v));
        return int'(v);
    endfunction

    function automatic logic [N*32-1:0] row_ref(input int i, input bit use_new);
        logic [N-1:0][31:0] r;
        for (int j = 0; j < N; j++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < N; k++) begin
                acc += ext8(xr[i][k], xsg[i]) *
                       (use_new ? ext8(shd_w[k][j], shd_s[k]) : ext8(act_w[k][j], act_s[k]));
            end
            r[j] = acc;
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < N; r++) begin
            shd_s[r] = 1'b0;
            act_s[r] = 1'b0;
            for (int c = 0; c < N; c++) begin
                shd_w[r][c] = 8'h00;
                act_w[r][c] = 8'h00;
            end
        end
    endtask

    task automatic random_weights();
        for (int r = 0; r < N; r++) begin
            new_s[r] = 1'($urandom);
            for (int c = 0; c < N; c++) new_w[r][c] = 8'($urandom);
        end
    endtask

    task automatic random_rows(input int n);
        for (int i = 0; i < n; i++) begin
            xsg[i] = 1'($urandom);
            for (int k = 0; k < N; k++) xr[i][k] = 8'($urandom);
        end
    endtask

    // Writes new_w/new_s into the shadow rows, then one out-of-range write.
    task automatic load_shadow();
        for (int r = 0; r < N; r++) begin
            enable          = 1'($urandom);
            activate_weight = 1'b0;
            systolic_data   = '0;
            load_weight     = 1'b1;
            weight_addr     = 8'(r);
            weight_signed   = new_s[r];
            for (int c = 0; c < N; c++) weight_data[c] = new_w[r][c];
            @(posedge clk);
            shd_s[r] = new_s[r];
            for (int c = 0; c < N; c++) shd_w[r][c] = new_w[r][c];
            @(negedge clk);
        end
        weight_addr   = 8'($urandom_range(N, 255));
        weight_signed = 1'($urandom);
        for (int c = 0; c < N; c++) weight_data[c] = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        load_weight = 1'b0;
        enable      = 1'b0;
    endtask

    // Streams nrows skewed rows (act_step < 0: no activation; stall_step:
    // insert 3 disabled cycles before that step; rst_step: async reset).
    task automatic run_stream(input string name, input int nrows, input int act_step,
                              input int stall_step, input int rst_step);
        logic [N*32-1:0] exp_row [MAXR];
        logic [N*32-1:0] last_exp;
        bit              last_vld;
        int              e;
        $display("stream %s rows=%0d act=%0d stall=%0d rst=%0d",
                 name, nrows, act_step, stall_step, rst_step);
        for (int i = 0; i < nrows; i++)
            exp_row[i] = row_ref(i, (act_step >= 0) && (i >= act_step));
        last_exp = '0;
        last_vld = 1'b0;
        for (int s = 0; s < nrows + N + 2; s++) begin
            if (s == stall_step) begin
                for (int c = 0; c < 3; c++) begin
                    enable          = 1'b0;
                    activate_weight = 1'($urandom);
                    systolic_signed = 1'($urandom);
                    for (int k = 0; k < N; k++) systolic_data[k] = 8'($urandom);
`ifdef MMU_RESULT_VALID_EN
                    systolic_valid  = 1'($urandom);
`endif
                    @(posedge clk);
                    @(negedge clk);
                    check($sformatf("%s stall s%0d c%0d", name, s, c), result, last_exp);
`ifdef MMU_RESULT_VALID_EN
                    check($sformatf("%s stall_vld s%0d", name, s),
                          {{(N*32-1){1'b0}}, result_valid}, {{(N*32-1){1'b0}}, last_vld});
`endif
                end
            end
            enable          = 1'b1;
            activate_weight = (s == act_step);
            for (int k = 0; k < N; k++) begin
                int r;
                r = s - k;
                systolic_data[k] = (r >= 0 && r < nrows) ? xr[r][k] : 8'h00;
            end
            systolic_signed = (s < nrows) ? xsg[s] : 1'($urandom);
`ifdef MMU_RESULT_VALID_EN
            systolic_valid  = (s < nrows);
`endif
            @(posedge clk);
            if (s == rst_step) begin
                #2 rst = 1'b0;
                #1 check($sformatf("%s async_rst s%0d", name, s), result, '0);
`ifdef MMU_RESULT_VALID_EN
                check($sformatf("%s rst_vld", name), {{(N*32-1){1'b0}}, result_valid}, '0);
`endif
                rst = 1'b1;
                @(negedge clk);
                enable          = 1'b0;
                activate_weight = 1'b0;
                systolic_data   = '0;
                clear_model();
                return;
            end
            @(negedge clk);
            e        = s - N - 1;
            last_vld = (e >= 0 && e < nrows);
            last_exp = last_vld ? exp_row[e] : '0;
            check($sformatf("%s s%0d", name, s), result, last_exp);
`ifdef MMU_RESULT_VALID_EN
            check($sformatf("%s vld s%0d", name, s),
                  {{(N*32-1){1'b0}}, result_valid}, {{(N*32-1){1'b0}}, last_vld});
`endif
        end
        enable          = 1'b0;
        activate_weight = 1'b0;
        systolic_data   = '0;
        if (act_step >= 0 && act_step < nrows + N + 2) begin
            for (int r = 0; r < N; r++) begin
                act_s[r] = shd_s[r];
                for (int c = 0; c < N; c++) act_w[r][c] = shd_w[r][c];
            end
        end
    endtask

    task automatic set_row(input int r, input int a, input int b, input int c, input int d);
        new_w[r][0] = 8'(a); new_w[r][1] = 8'(b); new_w[r][2] = 8'(c); new_w[r][3] = 8'(d);
    endtask

    task automatic set_x(input int i, input bit sg, input int a, input int b, input int c, input int d);
        xsg[i] = sg;
        xr[i][0] = 8'(a); xr[i][1] = 8'(b); xr[i][2] = 8'(c); xr[i][3] = 8'(d);
    endtask

    initial begin
        rst             = 1'b0;
        enable          = 1'b0;
        weight_data     = '0;
        weight_signed   = 1'b0;
        systolic_data   = '0;
        systolic_signed = 1'b0;
        activate_weight = 1'b0;
        load_weight     = 1'b0;
        weight_addr     = 8'h00;
`ifdef MMU_RESULT_VALID_EN
        systolic_valid  = 1'b0;
`endif
        clear_model();
        repeat (3) @(negedge clk);
        check("reset_result", result, '0);
`ifdef MMU_RESULT_VALID_EN
        check("reset_valid", {{(N*32-1){1'b0}}, result_valid}, '0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // unsigned weights, activation together with the first row
        set_row(0, 29, 78, 212, 98);  set_row(1, 3, 14, 73, 255);
        set_row(2, 18, 245, 184, 84); set_row(3, 9, 178, 89, 13);
        for (int r = 0; r < N; r++) new_s[r] = 1'b0;
        load_shadow();
        set_x(0, 1'b0, 2, 122, 84, 30);
        set_x(1, 1'b0, 30, 8, 120, 255);
        run_stream("unsigned", 2, 0, -1, -1);

        // signed weights
        set_row(0, 29, 78, 127, -98); set_row(1, 3, 14, 73, -128);
        set_row(2, 18, 86, 104, -84); set_row(3, 9, 92, 89, -13);
        for (int r = 0; r < N; r++) new_s[r] = 1'b1;
        load_shadow();
        set_x(0, 1'b0, 8, 92, 26, 94);
        run_stream("signed_w", 1, 0, -1, -1);

        // signed vs unsigned input with a single nonzero weight
        for (int r = 0; r < N; r++) set_row(r, 0, 0, 0, 0);
        new_w[0][0] = 8'd2;
        for (int r = 0; r < N; r++) new_s[r] = 1'b0;
        load_shadow();
        set_x(0, 1'b1, 255, 0, 0, 0);
        set_x(1, 1'b0, 255, 0, 0, 0);
        run_stream("signed_x", 2, 0, -1, -1);

        // stall mid-stream with random weights
        random_weights();
        load_shadow();
        random_rows(8);
        run_stream("stall", 8, 0, 5, -1);

        // randomized streams: partial activation, no activation, stalls
        for (int t = 0; t < 8; t++) begin
            int n, a, st;
            random_weights();
            load_shadow();
            n  = $urandom_range(1, 12);
            a  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, n - 1);
            st = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, n + N + 1);
            random_rows(n);
            run_stream($sformatf("rand%0d", t), n, a, st, -1);
        end

        // reset mid-stream, then everything reads zero until reload
        random_rows(6);
        run_stream("reset", 6, -1, -1, 2);
        random_rows(6);
        run_stream("post_rst", 6, -1, -1, -1);
        random_rows(6);
        run_stream("post_rst_act", 6, 0, -1, -1);
        random_weights();
        load_shadow();
        random_rows(6);
        run_stream("reload", 6, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
